muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer for the MIPS pipeline. It executes MULT, MULTU, DIV and DIVU over WIDTH+2 cycles.
//  It owns the HI/LO registers and handles MTHI/MTLO writes. It issues a stall to the ID/EX stages when a HI/LO access hits a busy unit.
//  It sits beside the ALU in EX and takes operands after forwarding.

---
 rtl/mips_muldiv_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
// Holds op and FSM state enums plus the counter width helper.
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring shift-subtract divide step.
// acc is the product high half / partial remainder, aux the multiplier / dividend-quotient register.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] aux,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] aux_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (aux[0] ? {1'b0, b} : '0);
        shifted = {acc, aux[WIDTH-1]};
        diff    = shifted - {1'b0, b};
        acc_nxt = '0;
        aux_nxt = '0;
        if (is_div) begin
            // Partial remainder is below b, so a set top bit of diff means the subtract borrowed
            if (diff[WIDTH]) begin
                acc_nxt = shifted[WIDTH-1:0];
                aux_nxt = {aux[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = diff[WIDTH-1:0];
                aux_nxt = {aux[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt = sum[WIDTH:1];
            aux_nxt = {sum[0], aux[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// MIPS HI/LO multiply/divide unit: magnitudes iterate WIDTH steps, then signs are fixed in one cycle.
// Start accepted in IDLE only; busy for WIDTH+1 cycles, done pulses as busy drops; stall gates HI/LO users.
module muldiv_seq
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             fix;
    logic [CW-1:0]    cnt;
    op_t              op_in;
    op_t              op_q;
    logic             is_div;
    logic             signed_op;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] aux;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] rs_raw;
    logic             neg_lo;
    logic             neg_hi;
    logic             div_zero;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] aux_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign op_in     = op_t'(op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign rs_neg    = signed_op & rs_val[WIDTH-1];
    assign rt_neg    = signed_op & rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_val : rs_val;
    assign rt_mag    = rt_neg ? -rt_val : rt_val;
    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_FIXUP;
                end
            end
            S_FIXUP: begin
                busy      = 1'b1;
                fix       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign stall = busy & (start | mf_req | hi_we | lo_we);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc     (acc),
        .aux     (aux),
        .b       (opb),
        .acc_nxt (acc_nxt),
        .aux_nxt (aux_nxt)
    );

    // Mul: aux holds the multiplier, opb the multiplicand. Div: aux holds the dividend, opb the divisor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= OP_MULT;
            acc      <= '0;
            aux      <= '0;
            opb      <= '0;
            rs_raw   <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            cnt      <= '0;
            op_q     <= op_in;
            acc      <= '0;
            aux      <= op[1] ? rs_mag : rt_mag;
            opb      <= op[1] ? rt_mag : rs_mag;
            rs_raw   <= rs_val;
            neg_lo   <= rs_neg ^ rt_neg;
            neg_hi   <= op[1] ? rs_neg : (rs_neg ^ rt_neg);
            div_zero <= op[1] & (rt_val == '0);
        end else if (step) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
            aux <= aux_nxt;
        end
    end

    assign prod     = {acc, aux};
    assign prod_fix = neg_lo ? -prod : prod;
    assign q_fix    = neg_lo ? -aux : aux;
    assign r_fix    = neg_hi ? -acc : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fix;
            if (fix) begin
                if (div_zero) begin
                    hi <= rs_raw;
                    lo <= '1;
                end else if (is_div) begin
                    hi <= r_fix;
                    lo <= q_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end else if (!busy) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table for arithmetic and latency, hand sequences for
// MTHI/MTLO, stall while busy, start in the done cycle and reset mid-operation.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         mf_req;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .mf_req (mf_req),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one edge; returns sampled just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cyc, output int stall_cyc);
        edges     = 0;
        busy_cyc  = 0;
        stall_cyc = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busy_cyc++;
            if (stall === 1'b1) stall_cyc++;
            tick();
            edges++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int e, bc, sc, dcnt;

        vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{2'b01, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14};
        vecs[4] = '{2'b11, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
        vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
        vecs[8] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[9] = '{2'b10, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        mf_req = 1'b1;
        repeat (3) tick();
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        check("rst_stall", stall, 0);
        check("rst_hi",    hi,    0);
        check("rst_lo",    lo,    0);
        mf_req = 1'b0;
        rst_n  = 1'b1;
        tick();

        // Accept edge E0; done and results appear after edge E33, busy covers E0..E32 samples
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            wait_done(e, bc, sc);
            check($sformatf("v%0d_latency", i), e, 33);
            check($sformatf("v%0d_busy_cycles", i), bc, 33);
            check($sformatf("v%0d_busy_at_done", i), busy, 0);
            check($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].elo);
            tick();
            check($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // MTHI alone, then MTHI+MTLO together
        hi_we = 1'b1;
        wdata = 32'h1111_1111;
        tick();
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'h1111_1111);
        check("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h2222_2222;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("both_hi", hi, 32'h2222_2222);
        check("both_lo", lo, 32'h2222_2222);

        // Start and MTLO on the same idle edge: write lands, result overwrites later
        lo_we = 1'b1;
        wdata = 32'h0000_0055;
        issue(2'b01, 32'd2, 32'd3);
        lo_we = 1'b0;
        check("startwr_lo_now", lo, 32'h55);
        check("startwr_busy", busy, 1);
        wait_done(e, bc, sc);
        check("startwr_latency", e, 33);
        check("startwr_hi", hi, 0);
        check("startwr_lo", lo, 6);
        tick();

        // Requests held during busy: stall every busy cycle, writes and restart ignored
        issue(2'b11, 32'd100, 32'd7);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd5;
        rt_val = 32'd6;
        mf_req = 1'b1;
        hi_we  = 1'b1;
        lo_we  = 1'b1;
        wdata  = 32'hDEAD_BEEF;
        check("busy_stall_e0", stall, 1);
        repeat (5) tick();
        check("busy_mtlo_lo", lo, 6);
        check("busy_mthi_hi", hi, 0);
        wait_done(e, bc, sc);
        check("held_latency", e, 28);
        check("held_busy_cycles", bc, 28);
        check("held_stall_cycles", sc, 28);
        check("held_done_stall", stall, 0);
        check("held_hi", hi, 2);
        check("held_lo", lo, 14);
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        mf_req = 1'b0;
        tick();
        check("done_cycle_accept_busy", busy, 1);
        check("done_cycle_accept_done", done, 0);
        start = 1'b0;
        wait_done(e, bc, sc);
        check("second_latency", e, 33);
        check("second_hi", hi, 0);
        check("second_lo", lo, 30);
        tick();

        // Reset during a MULT: everything clears and no done follows
        hi_we = 1'b1;
        wdata = 32'h0000_0077;
        tick();
        hi_we = 1'b0;
        issue(2'b00, 32'hFFFF_FFFE, 32'd3);
        repeat (9) tick();
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hi",   hi,   0);
        check("midrst_lo",   lo,   0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done === 1'b1) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        check("midrst_hi_after", hi, 0);
        check("midrst_lo_after", lo, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
